// File: rtl/vic_if.sv
// ---------------------------------------------------------------------------
// vic_if : signal bundle between the interrupt sources/CPU side and vic_param.
//
// slave  modport (used by vic_param):
//   in : irq, mask_wr/mask_in, mode_wr/mode_in, vec_wr/vec_addr/vec_data,
//        set_ien, clr_ien, ack, eoi
//   out: i_pend, data_out, act_id, in_service
// master modport: the mirror image, for whoever drives the controller.
// ---------------------------------------------------------------------------
interface vic_if #(
    parameter int AW = 3,
    parameter int VW = 8
);
    localparam int NCH = 2**AW;

    logic [NCH-1:0] irq;
    logic           mask_wr;
    logic [NCH-1:0] mask_in;
    logic           mode_wr;
    logic [NCH-1:0] mode_in;
    logic           vec_wr;
    logic [AW-1:0]  vec_addr;
    logic [VW-1:0]  vec_data;
    logic           set_ien;
    logic           clr_ien;
    logic           ack;
    logic           eoi;
    logic           i_pend;
    logic [VW-1:0]  data_out;
    logic [AW-1:0]  act_id;
    logic           in_service;

    modport slave (
        input  irq, mask_wr, mask_in, mode_wr, mode_in,
               vec_wr, vec_addr, vec_data, set_ien, clr_ien, ack, eoi,
        output i_pend, data_out, act_id, in_service
    );

    modport master (
        output irq, mask_wr, mask_in, mode_wr, mode_in,
               vec_wr, vec_addr, vec_data, set_ien, clr_ien, ack, eoi,
        input  i_pend, data_out, act_id, in_service
    );
endinterface

// File: rtl/vic_param.sv
// ---------------------------------------------------------------------------
// vic_param : parameterised vectored interrupt controller.
//
// NCH = 2**AW interrupt lines, each with a mask bit and an edge/level mode.
// Fixed priority, highest index wins. The winning channel's vector comes
// from a writable table (reset contents: entry k = k). An ack moves the
// controller to SERVICE, which blocks further requests until eoi.
//
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : vic_if.slave (irq, config writes, ien control, ack/eoi in;
//            i_pend, data_out, act_id, in_service out)
//
// State table:
//   ST_IDLE    | waiting for an enabled request; i_pend may assert
//   ST_SERVICE | one channel accepted, ISR running; i_pend held low
// ---------------------------------------------------------------------------
module vic_param #(
    parameter int AW = 3,
    parameter int VW = 8
) (
    input  logic    clk,
    input  logic    rst_n,
    vic_if.slave    bus
);
    localparam int NCH = 2**AW;

    typedef enum logic {ST_IDLE, ST_SERVICE} state_t;

    state_t          state_q;
    logic [NCH-1:0]  irq_q;
    logic [NCH-1:0]  epend_q, epend_d;
    logic [NCH-1:0]  mask_q;
    logic [NCH-1:0]  mode_q;
    logic            ien_q, ien_d;
    logic [VW-1:0]   vec_tbl_q [NCH];
    logic [VW-1:0]   data_out_q;
    logic [AW-1:0]   act_id_q;
    logic            in_service_q;

    logic [NCH-1:0]  req;
    logic [NCH-1:0]  eff;
    logic [AW-1:0]   win_id;
    logic            i_pend;
    logic            accept;
    logic            finish;

    // Edge channels request from their sticky pending bit, level channels
    // straight from the registered line.
    assign req = (mode_q & epend_q) | (~mode_q & irq_q);
    assign eff = req & mask_q;

    // Ascending scan: the last (highest) set index is left in win_id.
    always_comb begin
        win_id = '0;
        for (int k = 0; k < NCH; k++) begin
            if (eff[k]) begin
                win_id = AW'(k);
            end
        end
    end

    assign i_pend = ien_q & (|eff) & (state_q == ST_IDLE);
    assign accept = i_pend & bus.ack;
    assign finish = (state_q == ST_SERVICE) & bus.eoi;

    always_comb begin
        epend_d = epend_q;
        if (accept) begin
            epend_d[win_id] = 1'b0;
        end
        // A new edge is applied after the accept-clear so it is never lost.
        epend_d = epend_d | (bus.irq & ~irq_q & mode_q);
        // Switching a channel back to level drops any stale edge.
        if (bus.mode_wr) begin
            epend_d = epend_d & bus.mode_in;
        end
    end

    always_comb begin
        ien_d = ien_q;
        if (accept) begin
            ien_d = 1'b0;
        end
        if (finish) begin
            ien_d = 1'b1;
        end
        if (bus.set_ien) begin
            ien_d = 1'b1;
        end
        if (bus.clr_ien) begin
            ien_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            irq_q        <= '0;
            epend_q      <= '0;
            mask_q       <= '0;
            mode_q       <= '0;
            ien_q        <= 1'b0;
            data_out_q   <= '0;
            act_id_q     <= '0;
            in_service_q <= 1'b0;
            for (int k = 0; k < NCH; k++) begin
                vec_tbl_q[k] <= VW'(k);
            end
        end else begin
            irq_q   <= bus.irq;
            epend_q <= epend_d;
            ien_q   <= ien_d;
            if (bus.mask_wr) begin
                mask_q <= bus.mask_in;
            end
            if (bus.mode_wr) begin
                mode_q <= bus.mode_in;
            end
            // Non-blocking update: a capture in the same cycle sees the old entry.
            if (bus.vec_wr) begin
                vec_tbl_q[bus.vec_addr] <= bus.vec_data;
            end
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_q      <= ST_SERVICE;
                        act_id_q     <= win_id;
                        data_out_q   <= vec_tbl_q[win_id];
                        in_service_q <= 1'b1;
                    end
                end
                ST_SERVICE: begin
                    if (finish) begin
                        state_q      <= ST_IDLE;
                        in_service_q <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= ST_IDLE;
                    in_service_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.i_pend     = i_pend;
    assign bus.data_out   = data_out_q;
    assign bus.act_id     = act_id_q;
    assign bus.in_service = in_service_q;

endmodule

// File: tb/tb_vic_param.sv
// ---------------------------------------------------------------------------
// tb_vic_param : self-checking bench for vic_param (AW=3, VW=8).
// ---------------------------------------------------------------------------
module tb_vic_param;
    localparam int AW  = 3;
    localparam int VW  = 8;
    localparam int NCH = 2**AW;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vic_if #(.AW(AW), .VW(VW)) bus ();

    vic_param #(.AW(AW), .VW(VW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Behavioural reference state
    bit          m_irq_q [NCH];
    bit          m_epend [NCH];
    bit          m_mask  [NCH];
    bit          m_mode  [NCH];
    bit          m_ien;
    bit          m_svc;
    int          m_tbl   [NCH];
    int          m_data;
    int          m_id;

    typedef struct {
        logic [NCH-1:0] irq;
        logic [NCH-1:0] mask;
        bit             exp_pend;
        int             exp_id;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int m_win();
        for (int k = NCH-1; k >= 0; k--) begin
            bit r;
            r = m_mode[k] ? m_epend[k] : m_irq_q[k];
            if (r && m_mask[k]) return k;
        end
        return -1;
    endfunction

    function automatic bit m_pend();
        return m_ien && !m_svc && (m_win() >= 0);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NCH; k++) begin
            m_irq_q[k] = 0; m_epend[k] = 0; m_mask[k] = 0; m_mode[k] = 0;
            m_tbl[k] = k;
        end
        m_ien = 0; m_svc = 0; m_data = 0; m_id = 0;
    endtask

    task automatic model_clock();
        int w;
        bit acc, fin, nien;
        bit nep [NCH];
        w    = m_win();
        acc  = m_pend() && bus.ack;
        fin  = m_svc && bus.eoi;
        nep  = m_epend;
        if (acc) nep[w] = 0;
        for (int k = 0; k < NCH; k++) begin
            if (bus.irq[k] && !m_irq_q[k] && m_mode[k]) nep[k] = 1;
            if (bus.mode_wr && !bus.mode_in[k]) nep[k] = 0;
        end
        nien = m_ien;
        if (acc) nien = 0;
        if (fin) nien = 1;
        if (bus.set_ien) nien = 1;
        if (bus.clr_ien) nien = 0;
        if (acc) begin
            m_data = m_tbl[w];
            m_id   = w;
            m_svc  = 1;
        end
        if (fin) m_svc = 0;
        for (int k = 0; k < NCH; k++) begin
            if (bus.mask_wr) m_mask[k] = bus.mask_in[k];
            if (bus.mode_wr) m_mode[k] = bus.mode_in[k];
            m_irq_q[k] = bus.irq[k];
        end
        if (bus.vec_wr) m_tbl[bus.vec_addr] = int'(bus.vec_data);
        m_epend = nep;
        m_ien   = nien;
    endtask

    task automatic cmp_model();
        chk("i_pend",     32'(bus.i_pend),     32'(m_pend()));
        chk("data_out",   32'(bus.data_out),   32'(m_data));
        chk("act_id",     32'(bus.act_id),     32'(m_id));
        chk("in_service", 32'(bus.in_service), 32'(m_svc));
    endtask

    // One clock: model advances with the inputs set up before the edge,
    // outputs are compared 1 ns later, strobes drop at the next negedge.
    task automatic step();
        @(posedge clk);
        if (rst_n) model_clock(); else model_reset();
        #1;
        cmp_model();
        @(negedge clk);
        bus.mask_wr = 0; bus.mode_wr = 0; bus.vec_wr = 0;
        bus.set_ien = 0; bus.clr_ien = 0; bus.ack = 0; bus.eoi = 0;
    endtask

    initial begin
        bus.irq = '0; bus.mask_wr = 0; bus.mask_in = '0; bus.mode_wr = 0;
        bus.mode_in = '0; bus.vec_wr = 0; bus.vec_addr = '0; bus.vec_data = '0;
        bus.set_ien = 0; bus.clr_ien = 0; bus.ack = 0; bus.eoi = 0;

        vecs[0] = '{irq: 8'h81, mask: 8'h7F, exp_pend: 1, exp_id: 0};
        vecs[1] = '{irq: 8'h81, mask: 8'hFF, exp_pend: 1, exp_id: 7};
        vecs[2] = '{irq: 8'h00, mask: 8'hFF, exp_pend: 0, exp_id: 0};
        vecs[3] = '{irq: 8'h24, mask: 8'h00, exp_pend: 0, exp_id: 0};
        vecs[4] = '{irq: 8'hF0, mask: 8'h0F, exp_pend: 0, exp_id: 0};
        vecs[5] = '{irq: 8'h0F, mask: 8'h0F, exp_pend: 1, exp_id: 3};
        vecs[6] = '{irq: 8'h42, mask: 8'hFF, exp_pend: 1, exp_id: 6};
        vecs[7] = '{irq: 8'h18, mask: 8'h10, exp_pend: 1, exp_id: 4};

        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("rst_i_pend",   32'(bus.i_pend),     0);
        chk("rst_data_out", 32'(bus.data_out),   0);
        chk("rst_act_id",   32'(bus.act_id),     0);
        chk("rst_in_svc",   32'(bus.in_service), 0);
        rst_n = 1;

        // Basic level request, priority 5 over 2
        bus.mask_wr = 1; bus.mask_in = 8'hFF; bus.mode_wr = 1; bus.mode_in = 8'h00;
        bus.set_ien = 1; bus.irq = 8'h24;
        step();
        chk("basic_pend", 32'(bus.i_pend), 1);
        bus.ack = 1;
        step();
        chk("basic_id",   32'(bus.act_id),     5);
        chk("basic_vec",  32'(bus.data_out),   8'h05);
        chk("basic_svc",  32'(bus.in_service), 1);
        chk("basic_pend0", 32'(bus.i_pend),    0);
        bus.eoi = 1; bus.irq = '0;
        step();
        step();

        // Table-driven level-mode vectors (default vector table: entry k = k)
        for (int i = 0; i < 8; i++) begin
            bus.mask_wr = 1; bus.mask_in = vecs[i].mask; bus.irq = vecs[i].irq;
            step();
            chk($sformatf("vec%0d_pend", i), 32'(bus.i_pend), 32'(vecs[i].exp_pend));
            bus.ack = 1;
            step();
            chk($sformatf("vec%0d_svc", i), 32'(bus.in_service), 32'(vecs[i].exp_pend));
            if (vecs[i].exp_pend) begin
                chk($sformatf("vec%0d_id", i),  32'(bus.act_id),   32'(vecs[i].exp_id));
                chk($sformatf("vec%0d_vec", i), 32'(bus.data_out), 32'(vecs[i].exp_id));
            end
            bus.eoi = 1; bus.irq = '0;
            step();
            step();
        end

        // Edge mode on ch2 with a programmed vector
        bus.vec_wr = 1; bus.vec_addr = 3'd2; bus.vec_data = 8'hA0;
        bus.mask_wr = 1; bus.mask_in = 8'h04; bus.mode_wr = 1; bus.mode_in = 8'h04;
        step();
        bus.irq = 8'h04;
        step();
        bus.irq = 8'h00;
        step();
        chk("edge_pend_persist", 32'(bus.i_pend), 1);
        bus.ack = 1;
        step();
        chk("edge_vec", 32'(bus.data_out), 8'hA0);
        bus.eoi = 1;
        step();
        chk("edge_eoi_pend", 32'(bus.i_pend), 0);

        // Edge on ch3 arriving during its own service
        bus.mask_wr = 1; bus.mask_in = 8'h08; bus.mode_wr = 1; bus.mode_in = 8'h08;
        step();
        bus.irq = 8'h08; step();
        bus.irq = 8'h00; step();
        bus.ack = 1; step();
        chk("ch3_first_id", 32'(bus.act_id), 3);
        bus.irq = 8'h08; step();
        bus.irq = 8'h00; step();
        chk("ch3_svc_pend", 32'(bus.i_pend), 0);
        bus.eoi = 1; step();
        chk("ch3_repend", 32'(bus.i_pend), 1);
        bus.ack = 1; step();
        chk("ch3_second_id", 32'(bus.act_id), 3);
        bus.eoi = 1; step();

        // Mask ch7 then unmask while IDLE
        bus.mode_wr = 1; bus.mode_in = 8'h00; bus.mask_wr = 1; bus.mask_in = 8'h7F;
        bus.irq = 8'h81;
        step();
        bus.ack = 1; step();
        chk("masked7_id", 32'(bus.act_id), 0);
        bus.eoi = 1; step();
        bus.mask_wr = 1; bus.mask_in = 8'hFF; step();
        bus.ack = 1; step();
        chk("unmasked7_id", 32'(bus.act_id), 7);
        bus.eoi = 1; bus.irq = '0; step();

        // set_ien and clr_ien together, then level drop before ack
        bus.set_ien = 1; bus.clr_ien = 1; bus.irq = 8'h02; step();
        chk("setclr_pend", 32'(bus.i_pend), 0);
        bus.set_ien = 1; step();
        chk("level_pend", 32'(bus.i_pend), 1);
        bus.irq = 8'h00; step();
        chk("level_drop_pend", 32'(bus.i_pend), 0);
        bus.ack = 1; step();
        chk("level_drop_svc", 32'(bus.in_service), 0);

        // Reset during SERVICE
        bus.irq = 8'h04; step();
        bus.ack = 1; step();
        chk("pre_rst_svc", 32'(bus.in_service), 1);
        rst_n = 0;
        #1;
        model_reset();
        cmp_model();
        chk("mid_rst_svc", 32'(bus.in_service), 0);
        step();
        rst_n = 1;
        bus.irq = 8'h00; step();
        bus.irq = 8'h04; step();
        step();
        chk("post_rst_ignored", 32'(bus.i_pend), 0);
        bus.mask_wr = 1; bus.mask_in = 8'hFF; step();
        chk("post_rst_no_ien", 32'(bus.i_pend), 0);
        bus.set_ien = 1; step();
        chk("post_rst_pend", 32'(bus.i_pend), 1);
        bus.ack = 1; step();
        chk("post_rst_tbl", 32'(bus.data_out), 8'h02);
        bus.eoi = 1; bus.irq = '0; step();

        // Randomised traffic against the reference model
        for (int c = 0; c < 3000; c++) begin
            bus.irq     = NCH'($urandom) & NCH'($urandom);
            bus.ack     = ($urandom_range(0, 3) == 0);
            bus.eoi     = ($urandom_range(0, 4) == 0);
            bus.set_ien = ($urandom_range(0, 5) == 0);
            bus.clr_ien = ($urandom_range(0, 15) == 0);
            bus.mask_wr = ($urandom_range(0, 15) == 0);
            bus.mask_in = NCH'($urandom);
            bus.mode_wr = ($urandom_range(0, 15) == 0);
            bus.mode_in = NCH'($urandom);
            bus.vec_wr  = ($urandom_range(0, 7) == 0);
            bus.vec_addr = AW'($urandom);
            bus.vec_data = VW'($urandom);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/vic_param.md
# vic_param

Parameterised vectored interrupt controller: the successor to the 4-line, fixed-priority, mask-and-vector interrupt block. It accepts `NCH = 2**AW` interrupt lines, each with a runtime-programmable mask bit and edge/level mode. It resolves fixed priority (highest index wins) and delivers a vector from a writable on-chip vector table. An ack/end-of-interrupt handshake with the CPU control unit drives an IDLE/SERVICE state machine that suppresses new requests while one is being serviced. It sits between the peripheral interrupt lines and the PC-load logic of the 3-stage pipeline.

## Interface
- `AW`, 3, channel-index width; `NCH = 2**AW` channels (localparam), AW legal range 1..4
- `VW`, 8, vector (PC target) width
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `irq`  in  NCH  raw interrupt lines, synchronous to `clk`
- `mask_wr`, `mask_in`  in  1, NCH  load mask register (1 = channel enabled)
- `mode_wr`, `mode_in`  in  1, NCH  load mode register (1 = rising-edge, 0 = level)
- `vec_wr`, `vec_addr`, `vec_data`  in  1, AW, VW  vector-table write port
- `set_ien`, `clr_ien`  in  1 each  global interrupt enable set/clear
- `ack`  in  1  CPU accepts the pending interrupt
- `eoi`  in  1  CPU end-of-interrupt (return from ISR)
- `i_pend`  out  1  interrupt request to CPU
- `data_out`  out  VW  vector of the accepted channel
- `act_id`  out  AW  index of the accepted channel
- `in_service`  out  1  high while in SERVICE

## Operation
- Decided: one clock; reset asynchronous, active-low.
- Reset values: `i_pend`=0, `data_out`=0, `act_id`=0, `in_service`=0, ien=0, mask=0, mode=0 (all level), state=IDLE, `irq_q`=0, edge-pending=0, vector table entry k = k.
- Sampling: `irq_q <= irq` every cycle.
  - Edge-detect on a channel: `irq & ~irq_q`.
  - Edge-pending bit k is set on an edge of channel k while mode[k]=1, regardless of mask.
  - Edge-pending bit k is cleared only when channel k is accepted.
  - Set and clear in the same cycle: set wins, so no edge is lost.
  - Writing mode[k]=0 clears edge-pending bit k.
- Request per channel: `req[k] = mode[k] ? epend[k] : irq_q[k]`. Effective request: `eff = req & mask`.
- Priority: the highest set index of `eff` wins, giving `win_id`.
- `i_pend = ien & |eff & (state==IDLE)`. It is combinational from registers only.
- State IDLE:
  - `ack` while `i_pend`=1: on the next edge, state=SERVICE, `act_id<=win_id`, `data_out<=table[win_id]`, `in_service<=1`, ien<=0, and `epend[win_id]` is cleared.
  - `ack` while `i_pend`=0: ignored, no state change.
- State SERVICE:
  - `i_pend` is held at 0 (no nesting).
  - `eoi`: on the next edge, state=IDLE, `in_service<=0`, ien<=1. `data_out`/`act_id` hold their last value.
  - `ack` is ignored.
- `eoi` in IDLE: ignored.
- ien control:
  - `clr_ien` has priority over `set_ien`.
  - Both override the automatic clear on ack and the automatic set on eoi in the same cycle.
  - `set_ien` during SERVICE sets ien, but `i_pend` stays 0 until IDLE.
- `mask_wr`, `mode_wr`, `vec_wr`: synchronous writes that take effect on the next edge.
  - `vec_wr` to the entry being captured by an ack in the same cycle: `data_out` gets the old entry (read-before-write).
- `rst_n` low mid-SERVICE: immediate return to reset values. Pending edges are lost.

## Timing
- `irq` rising -> `i_pend` high: 1 cycle (through `irq_q`), provided mask, ien and IDLE hold.
- `ack` -> `data_out`/`act_id`/`in_service` valid: 1 cycle. `i_pend` falls in that same cycle.
- `eoi` -> `i_pend` may reassert: 1 cycle.
- Level channel that drops before `ack` is sampled: `i_pend` falls and the ack is ignored. There is no spurious service.
- `ack` and `eoi` in the same cycle: only the one legal for the current state acts.

## Test plan
- Reset, then `mask=8'hFF`, `mode=0`, `set_ien`; `irq=8'h24` -> `i_pend`=1 one cycle later. `ack` -> `act_id`=5, `data_out`=8'h05, `in_service`=1, `i_pend`=0.
- Program `table[2]=8'hA0` via `vec_wr`; mask only bit 2; edge mode on ch2. Pulse `irq[2]` for 1 cycle -> `i_pend`=1 persists after the pulse. `ack` -> `data_out`=8'hA0. `eoi` -> ien=1, `i_pend`=0.
- Edge ch3 arriving during SERVICE of ch3 -> after `eoi`, `i_pend`=1 again; second `ack` gives `act_id`=3.
- Mask 0 on ch7, `irq=8'h81` -> winner is 0, `act_id`=0. Unmask ch7 while IDLE -> after the write, the winner becomes 7.
- `set_ien` and `clr_ien` together -> ien=0, `i_pend`=0. Level `irq[1]` deasserted the cycle `ack` arrives with `i_pend`=0 -> no state change.
- `rst_n` low for 1 cycle during SERVICE -> all outputs 0, `table[k]=k`, a later `irq` is ignored until `set_ien`.
